// File: rtl/output_credit_ctrl.sv
// Credit-based flow controller for one switch output port: tracks downstream buffer credits,
// gates the allocator, checks wormhole framing and watches for stalls.
module output_credit_ctrl #(
    parameter int CREDITS       = 4,
    parameter int CW            = 3,
    parameter int HEAD_MIN_CRED = 1,
    parameter int STALL_LIMIT   = 255,
    parameter int PKT_CNT_W     = 16,
    parameter int FTYPEWD       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [FTYPEWD-1:0]   ftype_in,
    output logic                 busy_out,
    output logic                 valid_out,
    input  logic                 credit_in,
    output logic [CW-1:0]        credits,
    output logic                 in_packet,
    output logic [PKT_CNT_W-1:0] pkt_cnt,
    output logic                 stall_err,
    output logic                 proto_err,
    input  logic                 clr_err
);

    localparam logic [FTYPEWD-1:0] ENC_HEAD = FTYPEWD'(0);
    localparam logic [FTYPEWD-1:0] ENC_PAYL = FTYPEWD'(1);
    localparam logic [FTYPEWD-1:0] ENC_TAIL = FTYPEWD'(2);
    localparam logic [FTYPEWD-1:0] ENC_SING = FTYPEWD'(3);

    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
    localparam logic [CW-1:0] HEAD_MIN  = CW'(HEAD_MIN_CRED);
    localparam logic [7:0]    STALL_MAX = 8'(STALL_LIMIT);

    typedef enum logic {IDLE, PKT} state_t;

    state_t     state;
    logic [7:0] stall_cnt;
    logic       send;
    logic       blocked;
    logic       frame_err;
    logic       overflow;
    logic       stall_hit;

    // busy depends only on registered state so the allocator sees no combinational loop
    always_comb begin
        busy_out  = (credits == '0) | ((state == IDLE) & (credits < HEAD_MIN));
        send      = valid_in & ~busy_out;
        valid_out = send;
        blocked   = valid_in & busy_out;
        frame_err = send & (((state == IDLE) & ((ftype_in == ENC_PAYL) | (ftype_in == ENC_TAIL))) |
                            ((state == PKT)  & ((ftype_in == ENC_HEAD) | (ftype_in == ENC_SING))));
        overflow  = credit_in & ~send & (credits == CRED_MAX);
        stall_hit = blocked & (stall_cnt >= STALL_MAX - 8'd1);
    end

    assign in_packet = (state == PKT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits   <= CRED_MAX;
            state     <= IDLE;
            pkt_cnt   <= '0;
            stall_cnt <= '0;
            stall_err <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case ({send, credit_in})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   if (credits != CRED_MAX) credits <= credits + CW'(1);
                default: credits <= credits;
            endcase

            // A framing violation does not move the FSM; an open packet stays open
            if (send) begin
                case (state)
                    IDLE: begin
                        if (ftype_in == ENC_HEAD)
                            state <= PKT;
                        else if (ftype_in == ENC_SING)
                            pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
                    end
                    PKT: begin
                        if (ftype_in == ENC_TAIL) begin
                            state   <= IDLE;
                            pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (!valid_in || send)
                stall_cnt <= '0;
            else if (stall_cnt != STALL_MAX)
                stall_cnt <= stall_cnt + 8'd1;

            stall_err <= stall_hit | (stall_err & ~clr_err);
            proto_err <= frame_err | overflow | (proto_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_output_credit_ctrl.sv
// Self-checking bench for output_credit_ctrl: table-driven vectors through a scoreboard queue,
// plus hand sequences for reset mid-packet and the stall watchdog.
module tb_output_credit_ctrl;

    localparam logic [1:0] HEAD = 2'd0;
    localparam logic [1:0] PAYL = 2'd1;
    localparam logic [1:0] TAIL = 2'd2;
    localparam logic [1:0] SING = 2'd3;

    typedef struct {
        bit          b;
        logic        v;
        logic [1:0]  ft;
        logic        ci;
        logic        clr;
        logic        eBusy;
        logic        eVout;
        logic [2:0]  eCred;
        logic        eInPkt;
        logic [15:0] ePkt;
        logic        eProto;
        logic        eStall;
    } vec_t;

    logic clk;
    logic rst;
    logic [1:0] ftype;

    logic validA, creditA, clrA;
    logic busyA, voutA, inPktA, stallA, protoA;
    logic [2:0] credA;
    logic [15:0] pktA;

    logic validB, creditB, clrB;
    logic busyB, voutB, inPktB, stallB, protoB;
    logic [2:0] credB;
    logic [15:0] pktB;

    vec_t vecs[$];
    vec_t expQ[$];
    int   passed = 0;
    int   total = 0;
    int   stepNo = 0;
    logic sampBusy, sampVout;

    output_credit_ctrl dutA (
        .clk(clk), .rst(rst), .valid_in(validA), .ftype_in(ftype),
        .busy_out(busyA), .valid_out(voutA), .credit_in(creditA), .credits(credA),
        .in_packet(inPktA), .pkt_cnt(pktA), .stall_err(stallA), .proto_err(protoA),
        .clr_err(clrA)
    );

    output_credit_ctrl #(.HEAD_MIN_CRED(2)) dutB (
        .clk(clk), .rst(rst), .valid_in(validB), .ftype_in(ftype),
        .busy_out(busyB), .valid_out(voutB), .credit_in(creditB), .credits(credB),
        .in_packet(inPktB), .pkt_cnt(pktB), .stall_err(stallB), .proto_err(protoB),
        .clr_err(clrB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("[TB] FAIL step %0d %s: got %0h expected %0h", stepNo, name, act, exp);
    endfunction

    function automatic vec_t mkVec(bit b, logic v, logic [1:0] ft, logic ci, logic clr,
                                   logic eb, logic ev, int ec, logic ei, int ep,
                                   logic epr, logic es);
        vec_t t;
        t.b = b; t.v = v; t.ft = ft; t.ci = ci; t.clr = clr;
        t.eBusy = eb; t.eVout = ev; t.eCred = 3'(ec); t.eInPkt = ei;
        t.ePkt = 16'(ep); t.eProto = epr; t.eStall = es;
        return t;
    endfunction

    function automatic void addVec(bit b, logic v, logic [1:0] ft, logic ci, logic clr,
                                   logic eb, logic ev, int ec, logic ei, int ep,
                                   logic epr, logic es);
        vecs.push_back(mkVec(b, v, ft, ci, clr, eb, ev, ec, ei, ep, epr, es));
    endfunction

    // Pops the oldest expectation and compares it with what the selected DUT produced
    task automatic checkOutput();
        vec_t e;
        if (expQ.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = expQ.pop_front();
        check("busy_out",  {31'd0, sampBusy}, {31'd0, e.eBusy});
        check("valid_out", {31'd0, sampVout}, {31'd0, e.eVout});
        check("credits",   {29'd0, e.b ? credB : credA}, {29'd0, e.eCred});
        check("in_packet", {31'd0, e.b ? inPktB : inPktA}, {31'd0, e.eInPkt});
        check("pkt_cnt",   {16'd0, e.b ? pktB : pktA}, {16'd0, e.ePkt});
        check("proto_err", {31'd0, e.b ? protoB : protoA}, {31'd0, e.eProto});
        check("stall_err", {31'd0, e.b ? stallB : stallA}, {31'd0, e.eStall});
    endtask

    // Drives one cycle into the selected DUT (the other sits idle) and queues its expectation
    task automatic applyStimulus(input vec_t t);
        stepNo++;
        ftype   = t.ft;
        validA  = t.b ? 1'b0 : t.v;
        creditA = t.b ? 1'b0 : t.ci;
        clrA    = t.b ? 1'b0 : t.clr;
        validB  = t.b ? t.v  : 1'b0;
        creditB = t.b ? t.ci : 1'b0;
        clrB    = t.b ? t.clr : 1'b0;
        expQ.push_back(t);
        #1;
        sampBusy = t.b ? busyB : busyA;
        sampVout = t.b ? voutB : voutA;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkResetA(string tag);
        check({tag, "_busy"},  {31'd0, busyA},  32'd0);
        check({tag, "_vout"},  {31'd0, voutA},  32'd0);
        check({tag, "_cred"},  {29'd0, credA},  32'd4);
        check({tag, "_inpkt"}, {31'd0, inPktA}, 32'd0);
        check({tag, "_pkt"},   {16'd0, pktA},   32'd0);
        check({tag, "_proto"}, {31'd0, protoA}, 32'd0);
        check({tag, "_stall"}, {31'd0, stallA}, 32'd0);
    endtask

    initial begin
        // Four singles drain credits, then credit return, send+return, overflow, framing errors
        addVec(0,1,SING,0,0, 0,1, 3,0,1,0,0);
        addVec(0,1,SING,0,0, 0,1, 2,0,2,0,0);
        addVec(0,1,SING,0,0, 0,1, 1,0,3,0,0);
        addVec(0,1,SING,0,0, 0,1, 0,0,4,0,0);
        addVec(0,1,SING,0,0, 1,0, 0,0,4,0,0);
        addVec(0,1,SING,1,0, 1,0, 1,0,4,0,0);
        addVec(0,1,SING,0,0, 0,1, 0,0,5,0,0);
        addVec(0,0,SING,1,0, 1,0, 1,0,5,0,0);
        addVec(0,0,SING,1,0, 0,0, 2,0,5,0,0);
        addVec(0,1,SING,1,0, 0,1, 2,0,6,0,0);
        addVec(0,0,SING,1,0, 0,0, 3,0,6,0,0);
        addVec(0,0,SING,1,0, 0,0, 4,0,6,0,0);
        addVec(0,0,SING,1,0, 0,0, 4,0,6,1,0);
        addVec(0,0,SING,0,1, 0,0, 4,0,6,0,0);
        addVec(0,1,HEAD,0,0, 0,1, 3,1,6,0,0);
        addVec(0,1,PAYL,0,0, 0,1, 2,1,6,0,0);
        addVec(0,1,HEAD,0,0, 0,1, 1,1,6,1,0);
        addVec(0,1,TAIL,0,0, 0,1, 0,0,7,1,0);
        addVec(0,0,SING,1,1, 1,0, 1,0,7,0,0);
        addVec(0,0,SING,1,0, 0,0, 2,0,7,0,0);
        addVec(0,0,SING,1,0, 0,0, 3,0,7,0,0);
        addVec(0,0,SING,1,0, 0,0, 4,0,7,0,0);
        addVec(0,0,SING,1,1, 0,0, 4,0,7,1,0);
        addVec(0,0,SING,0,1, 0,0, 4,0,7,0,0);
        addVec(0,1,PAYL,0,0, 0,1, 3,0,7,1,0);
        addVec(0,0,SING,1,1, 0,0, 4,0,7,0,0);
        addVec(0,1,HEAD,0,0, 0,1, 3,1,7,0,0);
        addVec(0,1,SING,0,0, 0,1, 2,1,7,1,0);
        addVec(0,1,TAIL,0,0, 0,1, 1,0,8,1,0);
        addVec(0,0,SING,1,1, 0,0, 2,0,8,0,0);
        addVec(0,1,HEAD,0,0, 0,1, 1,1,8,0,0);
        // Second instance needs two credits to open a packet
        addVec(1,1,SING,0,0, 0,1, 3,0,1,0,0);
        addVec(1,1,SING,0,0, 0,1, 2,0,2,0,0);
        addVec(1,1,SING,0,0, 0,1, 1,0,3,0,0);
        addVec(1,1,HEAD,0,0, 1,0, 1,0,3,0,0);
        addVec(1,1,HEAD,1,0, 1,0, 2,0,3,0,0);
        addVec(1,1,HEAD,0,0, 0,1, 1,1,3,0,0);
        addVec(1,1,PAYL,0,0, 0,1, 0,1,3,0,0);
        addVec(1,1,TAIL,0,0, 1,0, 0,1,3,0,0);
        addVec(1,1,TAIL,1,0, 1,0, 1,1,3,0,0);
        addVec(1,1,TAIL,0,0, 0,1, 0,0,4,0,0);

        rst = 1'b0;
        ftype = SING;
        validA = 0; creditA = 0; clrA = 0;
        validB = 0; creditB = 0; clrB = 0;
        repeat (2) @(posedge clk);
        #1;
        checkResetA("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkResetA("post_reset");

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Asynchronous reset while dutA holds an open packet
        rst = 1'b0;
        #1;
        checkResetA("midpkt_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 1; i <= 4; i++)
            applyStimulus(mkVec(0,1,SING,0,0, 0,1, 4-i,0,i,0,0));
        for (int i = 0; i < 254; i++)
            applyStimulus(mkVec(0,1,SING,0,0, 1,0, 0,0,4,0,0));
        applyStimulus(mkVec(0,0,SING,0,0, 1,0, 0,0,4,0,0));
        for (int i = 0; i < 254; i++)
            applyStimulus(mkVec(0,1,SING,0,0, 1,0, 0,0,4,0,0));
        applyStimulus(mkVec(0,1,SING,0,0, 1,0, 0,0,4,0,1));
        applyStimulus(mkVec(0,1,SING,0,1, 1,0, 0,0,4,0,1));
        applyStimulus(mkVec(0,0,SING,0,1, 1,0, 0,0,4,0,0));
        applyStimulus(mkVec(0,0,SING,0,0, 1,0, 0,0,4,0,0));

        check("scoreboard_drained", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
